dispatch_buffer: RTL and testbench

- 4-wide dispatch staging FIFO between rename and the 4-in/1-out issue queue.
- Accepts one 4-instruction bundle per cycle from rename and holds bundles in a circular buffer.
- Drives the head bundle onto the issue queue's four instruction inputs, with an enable pulse whenever the issue queue can accept.
- Squashes killed instructions in place on branch kill; discards fully squashed bundles without sending them.

---
 rtl/dispatch_buffer.sv | 151 +++++++++++++++
 tb/tb_dispatch_buffer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dispatch_buffer.sv
// dispatch_buffer: 4-wide bundle staging FIFO between rename and the issue queue.
// Holds DEPTH bundles in a circular buffer, presents the head bundle combinationally,
// squashes killed slots in place, and silently drops bundles with no live slot.
//
// Handshake: o_en is asserted for exactly the cycles in which the head bundle is
// handed to the issue queue; it requires a head with at least one live slot and
// i_ready=1, and is never asserted in a flush cycle. Rename pushes with i_push and
// must respect o_full unless a pop happens in the same cycle.
module dispatch_buffer #(
   parameter int DEPTH     = 4,
   parameter int WIDTH_REG = 5,
   parameter int WIDTH_TAG = 5,
   parameter int WIDTH_BRM = 3,
   parameter int WIDTH     = 7 + WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + 3
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [WIDTH-1:0]           i_inst1,
   input  logic [WIDTH-1:0]           i_inst2,
   input  logic [WIDTH-1:0]           i_inst3,
   input  logic [WIDTH-1:0]           i_inst4,
   input  logic                       i_push,
   output logic                       o_full,
   output logic [WIDTH-1:0]           o_inst1,
   output logic [WIDTH-1:0]           o_inst2,
   output logic [WIDTH-1:0]           o_inst3,
   output logic [WIDTH-1:0]           o_inst4,
   output logic                       o_en,
   input  logic                       i_ready,
   input  logic [WIDTH_BRM-1:0]       i_BrKill,
   input  logic                       i_flush,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_SEND  = 2'd1,
      S_DROP  = 2'd2
   } head_state_t;

   logic [WIDTH-1:0] r_mem [DEPTH][4];
   logic [DEPTH-1:0] r_vld;
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;

   logic [WIDTH-1:0] w_in  [4];
   logic [WIDTH-1:0] w_out [4];
   logic             w_live;
   logic             w_any;
   head_state_t      w_state;
   logic             w_pop;
   logic             w_push;
   logic             w_full;

   // Clear the valid flag of a slot whose branch mask intersects the kill vector.
   function automatic logic [WIDTH-1:0] kill_slot(input logic [WIDTH-1:0] inst,
                                                   input logic [WIDTH_BRM-1:0] kill);
      logic [WIDTH-1:0] res;
      res = inst;
      if ((inst[WIDTH-8 -: WIDTH_BRM] & kill) != '0) res[0] = 1'b0;
      return res;
   endfunction

   // Incoming bundle filtered by the current kill before it is stored.
   always_comb begin
      w_in[0] = kill_slot(i_inst1, i_BrKill);
      w_in[1] = kill_slot(i_inst2, i_BrKill);
      w_in[2] = kill_slot(i_inst3, i_BrKill);
      w_in[3] = kill_slot(i_inst4, i_BrKill);
   end

   // Head view with this cycle's kill applied; zero when the buffer is empty.
   always_comb begin
      w_live = r_vld[r_head];
      for (int s = 0; s < 4; s++) begin
         w_out[s] = w_live ? kill_slot(r_mem[r_head][s], i_BrKill) : '0;
      end
      w_any = w_out[0][0] | w_out[1][0] | w_out[2][0] | w_out[3][0];
   end

   // Head state classification and the pop/push/enable decisions.
   always_comb begin
      w_state = S_EMPTY;
      w_pop   = 1'b0;
      o_en    = 1'b0;
      if (w_live) w_state = w_any ? S_SEND : S_DROP;
      case (w_state)
         S_SEND: begin
            o_en  = i_ready & ~i_flush;
            w_pop = i_ready & ~i_flush;
         end
         S_DROP:  w_pop = ~i_flush;
         default: ;
      endcase
      w_full = (r_count == CW'(DEPTH));
      w_push = i_push & (~w_full | w_pop) & ~i_flush;
   end

   assign o_inst1 = w_out[0];
   assign o_inst2 = w_out[1];
   assign o_inst3 = w_out[2];
   assign o_inst4 = w_out[3];
   assign o_full  = w_full;
   assign o_count = r_count;

   // Buffer storage, entry flags, pointers and occupancy count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int e = 0; e < DEPTH; e++) begin
            for (int s = 0; s < 4; s++) r_mem[e][s] <= '0;
         end
         r_vld   <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_vld   <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         // In-place squash of every stored slot hit by the kill.
         for (int e = 0; e < DEPTH; e++) begin
            for (int s = 0; s < 4; s++) begin
               if ((r_mem[e][s][WIDTH-8 -: WIDTH_BRM] & i_BrKill) != '0)
                  r_mem[e][s][0] <= 1'b0;
            end
         end
         // Pop clears first so a push into the freed entry (full case) wins.
         if (w_pop) begin
            r_vld[r_head] <= 1'b0;
            r_head        <= r_head + PW'(1);
         end
         if (w_push) begin
            for (int s = 0; s < 4; s++) r_mem[r_tail][s] <= w_in[s];
            r_vld[r_tail] <= 1'b1;
            r_tail        <= r_tail + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_dispatch_buffer.sv
// tb_dispatch_buffer: directed scenarios plus randomized traffic against a
// queue-based reference model of the dispatch buffer.
module tb_dispatch_buffer;

   localparam int DEPTH = 4;
   localparam int WB    = 3;
   localparam int WIDTH = 7 + WB + 5 + 3*5 + 3;
   localparam int BW    = 4 * WIDTH;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [WIDTH-1:0] i_inst1, i_inst2, i_inst3, i_inst4;
   logic [WIDTH-1:0] o_inst1, o_inst2, o_inst3, o_inst4;
   logic             i_push, o_full, o_en, i_ready, i_flush;
   logic [WB-1:0]    i_kill;
   logic [2:0]       o_count;

   dispatch_buffer #(.DEPTH(DEPTH), .WIDTH_REG(5), .WIDTH_TAG(5), .WIDTH_BRM(WB)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_inst1(i_inst1), .i_inst2(i_inst2), .i_inst3(i_inst3), .i_inst4(i_inst4),
      .i_push(i_push), .o_full(o_full),
      .o_inst1(o_inst1), .o_inst2(o_inst2), .o_inst3(o_inst3), .o_inst4(o_inst4),
      .o_en(o_en), .i_ready(i_ready), .i_BrKill(i_kill), .i_flush(i_flush),
      .o_count(o_count)
   );

   // scoreboard: bundles in push order, slot 1 in the low WIDTH bits
   logic [BW-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [WIDTH-1:0] make_inst(input logic [WB-1:0] m, input logic v);
      logic [WIDTH-1:0] w;
      w = '0;
      w[31:0] = $urandom;
      w[32]   = 1'($urandom_range(0, 1));
      w[WIDTH-8 -: WB] = m;
      w[0] = v;
      return w;
   endfunction

   function automatic logic [BW-1:0] rand_bundle();
      logic [BW-1:0] b;
      for (int s = 0; s < 4; s++) begin
         logic [WB-1:0] m;
         m = ($urandom_range(0, 1) == 0) ? '0 : WB'($urandom_range(1, 7));
         b[s*WIDTH +: WIDTH] = make_inst(m, $urandom_range(0, 9) != 0);
      end
      return b;
   endfunction

   function automatic logic [BW-1:0] kill_bundle(input logic [BW-1:0] b, input logic [WB-1:0] k);
      logic [BW-1:0] r;
      r = b;
      for (int s = 0; s < 4; s++) begin
         if ((b[s*WIDTH + WIDTH-8 -: WB] & k) != '0) r[s*WIDTH] = 1'b0;
      end
      return r;
   endfunction

   function automatic logic any_valid(input logic [BW-1:0] b);
      logic a;
      a = 1'b0;
      for (int s = 0; s < 4; s++) a = a | b[s*WIDTH];
      return a;
   endfunction

   // driver: one cycle of stimulus, check outputs before the edge, then advance the model
   task automatic step(input logic push, input logic [BW-1:0] b, input logic ready,
                       input logic [WB-1:0] kill, input logic flush);
      logic [BW-1:0] eb;
      logic          een, pop;
      int            sz;
      @(negedge clk);
      i_push = push; i_ready = ready; i_kill = kill; i_flush = flush;
      i_inst1 = b[0*WIDTH +: WIDTH]; i_inst2 = b[1*WIDTH +: WIDTH];
      i_inst3 = b[2*WIDTH +: WIDTH]; i_inst4 = b[3*WIDTH +: WIDTH];
      #1;
      sz = exp_q.size();
      if (sz == 0) begin
         eb = '0; een = 1'b0;
      end else begin
         eb  = kill_bundle(exp_q[0], kill);
         een = any_valid(eb) && ready && !flush;
      end
      check("inst",  {o_inst4, o_inst3, o_inst2, o_inst1}, eb);
      check("en",    BW'(o_en), BW'(een));
      check("count", BW'(o_count), BW'(sz));
      check("full",  BW'(o_full), BW'(sz == DEPTH));
      @(posedge clk);
      if (flush) begin
         exp_q.delete();
      end else begin
         for (int i = 0; i < exp_q.size(); i++) exp_q[i] = kill_bundle(exp_q[i], kill);
         pop = (sz > 0) && (!any_valid(exp_q[0]) || ready);
         if (pop) void'(exp_q.pop_front());
         if (push && (sz < DEPTH || pop)) exp_q.push_back(kill_bundle(b, kill));
      end
   endtask

   function automatic logic [BW-1:0] bundle_masks(input logic [WB-1:0] m1, input logic [WB-1:0] m2,
                                                  input logic [WB-1:0] m3, input logic [WB-1:0] m4);
      return {make_inst(m4, 1'b1), make_inst(m3, 1'b1), make_inst(m2, 1'b1), make_inst(m1, 1'b1)};
   endfunction

   initial begin
      i_push = 0; i_ready = 0; i_kill = '0; i_flush = 0;
      i_inst1 = '0; i_inst2 = '0; i_inst3 = '0; i_inst4 = '0;
      #2;
      check("rst_count", BW'(o_count), '0);
      check("rst_en", BW'(o_en), '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // idle after reset
      for (int i = 0; i < 10; i++) step(1'b0, rand_bundle(), 1'b1, '0, 1'b0);

      // fill with i_ready low, 5th push ignored, then drain in order
      for (int i = 0; i < 5; i++) step(1'b1, bundle_masks(0, 0, 0, 0), 1'b0, '0, 1'b0);
      check("full_hold", BW'(o_full), BW'(1));
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, '0, 1'b0);

      // full buffer with simultaneous push and pop across pointer wrap
      for (int i = 0; i < 4; i++) step(1'b1, bundle_masks(0, 0, 0, 0), 1'b0, '0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, bundle_masks(0, 0, 0, 0), 1'b1, '0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, '0, 1'b0);

      // kill of selected head slots, bundle still sent
      step(1'b1, bundle_masks(3'b001, 3'b010, 3'b000, 3'b011), 1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1, 3'b001, 1'b0);
      step(1'b0, '0, 1'b0, '0, 1'b0);

      // fully killed head is dropped without o_en
      step(1'b1, bundle_masks(3'b100, 3'b100, 3'b100, 3'b100), 1'b0, '0, 1'b0);
      step(1'b1, bundle_masks(0, 0, 0, 0), 1'b0, 3'b100, 1'b0);
      step(1'b0, '0, 1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0, '0, 1'b0);

      // flush with push in the same cycle
      step(1'b1, bundle_masks(0, 0, 0, 0), 1'b0, '0, 1'b0);
      step(1'b1, bundle_masks(0, 0, 0, 0), 1'b0, '0, 1'b0);
      step(1'b1, bundle_masks(0, 0, 0, 0), 1'b1, '0, 1'b1);
      step(1'b0, '0, 1'b1, '0, 1'b0);

      // asynchronous reset while o_en is high
      step(1'b1, bundle_masks(0, 0, 0, 0), 1'b0, '0, 1'b0);
      @(negedge clk);
      i_push = 0; i_ready = 1; i_kill = '0; i_flush = 0;
      #1;
      check("en_pre_rst", BW'(o_en), BW'(any_valid(exp_q[0])));
      #2 rst_n = 1'b0;
      #1;
      check("en_rst",    BW'(o_en), '0);
      check("count_rst", BW'(o_count), '0);
      check("inst_rst",  {o_inst4, o_inst3, o_inst2, o_inst1}, '0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, '0, 1'b1, '0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [WB-1:0] k;
         k = ($urandom_range(0, 7) == 0) ? WB'(1 << $urandom_range(0, WB-1)) : '0;
         step($urandom_range(0, 99) < 60, rand_bundle(), $urandom_range(0, 99) < 55,
              k, $urandom_range(0, 59) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
